// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: a WIDTH-bit add split into STAGES carry-linked slices, one per cycle,
// with valid/ready handshakes on both sides and carry, signed-overflow and zero flags.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp0,
    input  logic [WIDTH-1:0] inp1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
    end

    // Per stage: A and B' travel forward (skew), finished sum slices travel forward (de-skew).
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [SW:0]       slice;
    logic              advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // NOTE: every variable gets a full default before any partial update, so no latch is inferred.
    always_comb begin
        valid_d    = '0;
        c_d        = '0;
        valid_d[0] = in_valid;
        a_d[0]     = inp0;
        b_d[0]     = sub ? ~inp1 : inp1;
        s_d[0]     = '0;
        slice      = {1'b0, inp0[SW-1:0]} + {1'b0, b_d[0][SW-1:0]} + {{SW{1'b0}}, sub | cin};
        s_d[0][SW-1:0] = slice[SW-1:0];
        c_d[0]     = slice[SW];
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            s_d[k]     = s_q[k-1];
            slice      = {1'b0, a_q[k-1][k*SW +: SW]} + {1'b0, b_q[k-1][k*SW +: SW]}
                       + {{SW{1'b0}}, c_q[k-1]};
            s_d[k][k*SW +: SW] = slice[SW-1:0];
            c_d[k]     = slice[SW];
        end
    end

    // NOTE: the datapath registers are reset too, not just the valid bits, because the result
    // and flag outputs must read 0 straight after reset; non-blocking assignments keep the
    // stage-to-stage shift race-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            c_q     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            c_q     <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = s_q[LAST];
    assign carry     = c_q[LAST];
    assign overflow  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    // Qualified by valid so a cleared (all-zero) pipe does not report zero=1.
    assign zero      = out_valid && (s_q[LAST] == '0);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: 32-bit/4-stage main instance plus a 4-bit/1-stage
// instance driven with every {cin,B,A} combination.
module tb_pipelined_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, carry, overflow, zero;
    logic [31:0] inp0, inp1, sum;

    logic        s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready;
    logic        s_carry, s_overflow, s_zero;
    logic [3:0]  s_inp0, s_inp1, s_sum;

    int n_compared   = 0;
    int n_mismatched = 0;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .inp0(inp0), .inp1(inp1), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
    );

    pipelined_add_sub #(.WIDTH(4), .STAGES(1)) u_small (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .inp0(s_inp0), .inp1(s_inp1), .cin(s_cin), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .carry(s_carry), .overflow(s_overflow), .zero(s_zero)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_compared++;
        if ({sum, carry, overflow, zero} !== 35'd0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got sum=%h c=%b o=%b z=%b want all 0", sum, carry, overflow, zero);
        end
        n_compared++;
        if (s_out_valid !== 1'b0) begin
            n_mismatched++; $display("FAIL reset_small_valid: got %b want 0", s_out_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
    endtask

    // Columns: A, B, cin, sub, expected {carry, overflow, zero, sum}.
    task automatic test_add_sub();
        logic [31:0] ta [8] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0000,
                                32'h8000_0000, 32'h0000_0005, 32'h0000_1234, 32'h0000_000A};
        logic [31:0] tb [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_FFFF, 32'h8000_0000,
                                32'h0000_0001, 32'h0000_0007, 32'h0000_1234, 32'h0000_0003};
        logic        tc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [34:0] te [8] = '{{3'b101, 32'h0000_0000}, {3'b010, 32'h8000_0000},
                                {3'b000, 32'h1235_5678}, {3'b111, 32'h0000_0000},
                                {3'b110, 32'h7FFF_FFFF}, {3'b000, 32'hFFFF_FFFE},
                                {3'b101, 32'h0000_0000}, {3'b100, 32'h0000_0007}};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            inp0 = ta[i]; inp1 = tb[i]; cin = tc[i]; sub = ts[i]; in_valid = 1'b1;
            #1;
            n_compared++;
            if (in_ready !== 1'b1) begin
                n_mismatched++; $display("FAIL vec%0d_in_ready: got %b want 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_compared++;
            if (lat != 4) begin
                n_mismatched++; $display("FAIL vec%0d_latency: got %0d cycles want 4", i, lat);
            end
            n_compared++;
            if ({carry, overflow, zero, sum} !== te[i]) begin
                n_mismatched++;
                $display("FAIL vec%0d_result: got c=%b o=%b z=%b sum=%h want c=%b o=%b z=%b sum=%h",
                         i, carry, overflow, zero, sum, te[i][34], te[i][33], te[i][32], te[i][31:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q [8];
        logic [32:0] held;
        logic [31:0] a, b;
        int sent = 0;
        int got  = 0;
        int seen = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc < 9);
            a = 32'h2222_2222 * sent;
            b = 32'hF000_000F + sent;
            if (sent < 8) begin
                inp0 = a; inp1 = b; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                n_compared++;
                if ({out_valid, in_ready} !== 2'b10) begin
                    n_mismatched++;
                    $display("FAIL stall%0d_handshake: got out_valid=%b in_ready=%b want 1 0",
                             cyc, out_valid, in_ready);
                end
                if (cyc == 6) begin
                    held = {carry, sum};
                end else begin
                    n_compared++;
                    if ({carry, sum} !== held) begin
                        n_mismatched++;
                        $display("FAIL stall%0d_hold: got %h want %h", cyc, {carry, sum}, held);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_compared++;
                if ({carry, sum} !== exp_q[got]) begin
                    n_mismatched++;
                    $display("FAIL b2b_result%0d: got %h want %h", got, {carry, sum}, exp_q[got]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q[sent] = {1'b0, a} + {1'b0, b};
                sent++;
            end
        end
        in_valid = 1'b0;
        n_compared++;
        if (got != 8 || sent != 8) begin
            n_mismatched++; $display("FAIL b2b_count: got %0d out %0d in want 8 8", got, sent);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_compared++;
        if (seen != 0) begin
            n_mismatched++; $display("FAIL b2b_no_duplicate: got %0d extra results want 0", seen);
        end
    endtask

    task automatic test_reset_flush();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inp0 = 32'hFFFF_FFFF; inp1 = 32'd2 + i; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_compared++;
        if ({out_valid, carry, overflow, zero, sum} !== 36'd0) begin
            n_mismatched++;
            $display("FAIL flush_outputs: got v=%b c=%b o=%b z=%b sum=%h want all 0",
                     out_valid, carry, overflow, zero, sum);
        end
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_compared++;
        if (seen != 0) begin
            n_mismatched++; $display("FAIL flush_no_stale: got %0d results want 0", seen);
        end
    endtask

    task automatic test_exhaustive_4bit();
        logic [8:0] v, pv;
        logic [4:0] r;
        logic       ov;
        @(negedge clk);
        for (int i = 0; i <= 512; i++) begin
            if (i > 0) begin
                pv = 9'(i - 1);
                r  = {1'b0, pv[3:0]} + {1'b0, pv[7:4]} + {4'd0, pv[8]};
                ov = (pv[3] == pv[7]) && (r[3] != pv[3]);
                n_compared++;
                if ({s_out_valid, s_in_ready, s_carry, s_sum, s_overflow, s_zero}
                        !== {2'b11, r, ov, r[3:0] == 4'd0}) begin
                    n_mismatched++;
                    $display("FAIL exh_%03h: got v=%b c=%b sum=%h o=%b z=%b want v=1 c=%b sum=%h o=%b z=%b",
                             pv, s_out_valid, s_carry, s_sum, s_overflow, s_zero,
                             r[4], r[3:0], ov, r[3:0] == 4'd0);
                end
            end
            if (i < 512) begin
                v = 9'(i);
                {s_cin, s_inp1, s_inp0} = v;
                s_in_valid = 1'b1;
            end else begin
                s_in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; inp0 = '0; inp1 = '0; cin = 1'b0; sub = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_inp0 = '0; s_inp1 = '0; s_cin = 1'b0; s_sub = 1'b0;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_reset_flush();
        test_exhaustive_4bit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
